// File: rtl/dkong_rom_arbiter_pkg.sv
// Shared types and constants for the Donkey Kong ROM arbiter.
package dkong_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RDW,
    ACK
  } state_t;

  typedef enum logic {
    G_CPU = 1'b0,
    G_VID = 1'b1
  } grant_t;

  localparam int READ_LAT   = 3;
  localparam int ACC_CYCLES = 4;

endpackage

// File: rtl/dkong_rom_arbiter_rr_pick.sv
// Two-way round-robin chooser: req[0] is the CPU, req[1] is video.
module dkong_rr_pick
  import dkong_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = G_CPU;
    if (req == 2'b11) begin
      // On a tie the requester that was not served last time wins.
      grant = (last == G_CPU) ? G_VID : G_CPU;
    end else if (req[1]) begin
      grant = G_VID;
    end
  end

endmodule

// File: rtl/dkong_rom_arbiter.sv
// Single-port ROM arbiter: buffered download writes take priority over
// round-robin CPU / video reads.
module dkong_rom_arbiter
  import dkong_arb_pkg::*;
#(
  parameter int AW = 19,
  parameter int DW = 8
) (
  input  logic          I_CLK_24576M,
  input  logic          I_RESETn,
  input  logic          I_DN_ACTIVE,
  input  logic          I_DN_WR,
  input  logic [AW-1:0] I_DN_ADDR,
  input  logic [DW-1:0] I_DN_DATA,
  input  logic          I_CPU_REQ,
  input  logic [AW-1:0] I_CPU_ADDR,
  output logic [DW-1:0] O_CPU_DATA,
  output logic          O_CPU_ACK,
  input  logic          I_VID_REQ,
  input  logic [AW-1:0] I_VID_ADDR,
  output logic [DW-1:0] O_VID_DATA,
  output logic          O_VID_ACK,
  output logic [AW-1:0] O_MEM_ADDR,
  output logic [DW-1:0] O_MEM_D,
  output logic          O_MEM_WE,
  output logic          O_MEM_CE,
  input  logic [DW-1:0] I_MEM_Q,
  output logic          O_DN_OVF,
  output logic          O_DN_DONE
);

  state_t        state_q;
  state_t        state_next;
  grant_t        grant_q;
  grant_t        last_q;
  grant_t        pick;
  logic          pick_raw;
  logic          buf_full_q;
  logic [AW-1:0] buf_addr_q;
  logic [DW-1:0] buf_data_q;
  logic          active_q;
  logic          done_pending_q;
  logic          drain;
  logic          accept;
  logic          start_rd;
  logic          dn_fall;
  logic          done_cond;

  dkong_rr_pick u_pick (
    .req   ({I_VID_REQ, I_CPU_REQ}),
    .last  (last_q),
    .grant (pick_raw)
  );

  assign pick = grant_t'(pick_raw);

  // The buffer empties on the IDLE->WR edge, so a byte arriving on that
  // same edge can take its place without being counted as lost.
  assign drain     = (state_q == IDLE) && buf_full_q;
  assign accept    = I_DN_WR && (!buf_full_q || drain);
  assign start_rd  = (state_q == IDLE) && (state_next == RD);
  assign dn_fall   = active_q && !I_DN_ACTIVE;
  assign done_cond = (done_pending_q || dn_fall) && !I_DN_ACTIVE &&
                     !buf_full_q && (state_q != WR);

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          state_next = WR;
        end else if (!I_DN_ACTIVE && (I_CPU_REQ || I_VID_REQ)) begin
          state_next = RD;
        end
      end
      WR:      state_next = IDLE;
      RD:      state_next = RDW;
      RDW:     state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state_q        <= IDLE;
      grant_q        <= G_CPU;
      last_q         <= G_VID;
      buf_full_q     <= 1'b0;
      buf_addr_q     <= '0;
      buf_data_q     <= '0;
      active_q       <= 1'b0;
      done_pending_q <= 1'b0;
      O_CPU_DATA     <= '0;
      O_CPU_ACK      <= 1'b0;
      O_VID_DATA     <= '0;
      O_VID_ACK      <= 1'b0;
      O_MEM_ADDR     <= '0;
      O_MEM_D        <= '0;
      O_MEM_WE       <= 1'b0;
      O_MEM_CE       <= 1'b0;
      O_DN_OVF       <= 1'b0;
      O_DN_DONE      <= 1'b0;
    end else begin
      state_q  <= state_next;
      active_q <= I_DN_ACTIVE;

      if (start_rd) begin
        grant_q <= pick;
        last_q  <= pick;
      end

      if (accept) begin
        buf_addr_q <= I_DN_ADDR;
        buf_data_q <= I_DN_DATA;
        buf_full_q <= 1'b1;
      end else if (drain) begin
        buf_full_q <= 1'b0;
      end

      if (I_DN_ACTIVE && !active_q) begin
        O_DN_OVF <= 1'b0;
      end
      if (I_DN_WR && !accept) begin
        O_DN_OVF <= 1'b1;
      end

      // Memory controls are registered from the next state so they are
      // valid exactly during the WR / RD cycles.
      O_MEM_CE <= (state_next == WR) || (state_next == RD);
      O_MEM_WE <= (state_next == WR);
      if (drain) begin
        O_MEM_ADDR <= buf_addr_q;
        O_MEM_D    <= buf_data_q;
      end else if (start_rd) begin
        O_MEM_ADDR <= (pick == G_CPU) ? I_CPU_ADDR : I_VID_ADDR;
      end

      if (state_q == RDW) begin
        if (grant_q == G_CPU) begin
          O_CPU_DATA <= I_MEM_Q;
        end else begin
          O_VID_DATA <= I_MEM_Q;
        end
      end
      O_CPU_ACK <= (state_q == RDW) && (grant_q == G_CPU);
      O_VID_ACK <= (state_q == RDW) && (grant_q == G_VID);

      O_DN_DONE <= done_cond;
      if (I_DN_ACTIVE || done_cond) begin
        done_pending_q <= 1'b0;
      end else if (dn_fall) begin
        done_pending_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dkong_rom_arbiter.sv
// Scoreboard bench for dkong_rom_arbiter with a behavioural single-port ROM.
module tb_dkong_rom_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dn_active = 1'b0;
  logic          dn_wr = 1'b0;
  logic [AW-1:0] dn_addr = '0;
  logic [DW-1:0] dn_data = '0;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_data;
  logic          cpu_ack;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_data;
  logic          vid_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d;
  logic          mem_we;
  logic          mem_ce;
  logic [DW-1:0] mem_q = '0;
  logic          dn_ovf;
  logic          dn_done;

  logic [7:0] ram [0:4095];
  logic [7:0] cpu_exp_q [$];
  logic [7:0] vid_exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dkong_rom_arbiter #(.AW(AW), .DW(DW)) dut (
    .I_CLK_24576M (clk),
    .I_RESETn     (rst_n),
    .I_DN_ACTIVE  (dn_active),
    .I_DN_WR      (dn_wr),
    .I_DN_ADDR    (dn_addr),
    .I_DN_DATA    (dn_data),
    .I_CPU_REQ    (cpu_req),
    .I_CPU_ADDR   (cpu_addr),
    .O_CPU_DATA   (cpu_data),
    .O_CPU_ACK    (cpu_ack),
    .I_VID_REQ    (vid_req),
    .I_VID_ADDR   (vid_addr),
    .O_VID_DATA   (vid_data),
    .O_VID_ACK    (vid_ack),
    .O_MEM_ADDR   (mem_addr),
    .O_MEM_D      (mem_d),
    .O_MEM_WE     (mem_we),
    .O_MEM_CE     (mem_ce),
    .I_MEM_Q      (mem_q),
    .O_DN_OVF     (dn_ovf),
    .O_DN_DONE    (dn_done)
  );

  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) ram[mem_addr[11:0]] <= mem_d;
      else        mem_q <= ram[mem_addr[11:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every ack pops the next expected byte for that port.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_ack) begin
        check("cpu_ack_expected", cpu_exp_q.size() != 0, 1);
        if (cpu_exp_q.size() != 0) begin
          $display("cpu read data=0x%02h", cpu_data);
          check("cpu_data", cpu_data, cpu_exp_q.pop_front());
        end
      end
      if (vid_ack) begin
        check("vid_ack_expected", vid_exp_q.size() != 0, 1);
        if (vid_exp_q.size() != 0) begin
          $display("vid read data=0x%02h", vid_data);
          check("vid_data", vid_data, vid_exp_q.pop_front());
        end
      end
      if (cpu_ack || vid_ack) check("ack_exclusive", cpu_ack & vid_ack, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dn_active = 1'b0; dn_wr = 1'b0; cpu_req = 1'b0; vid_req = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Counts negedges until the next ack on either port, bounded.
  task automatic wait_any_ack(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(cpu_ack || vid_ack) && cycles < 40);
    if (!(cpu_ack || vid_ack)) check({tag, "_ack_timeout"}, 0, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cyc;
    int acks;
    int dones;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h123] = 8'h5A;
    ram[12'h100] = 8'hC1;
    ram[12'h200] = 8'hD2;

    // Reset state and a single CPU read.
    do_reset();
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_mem_ce", mem_ce, 0);
    check("rst_ovf", dn_ovf, 0);
    check("rst_done", dn_done, 0);
    check("rst_cpu_data", cpu_data, 0);
    cpu_addr = 19'h00123; cpu_req = 1'b1;
    cpu_exp_q.push_back(8'h5A);
    wait_any_ack("t1", cyc);
    check("t1_latency", cyc, 3);
    check("t1_cpu_ack", cpu_ack, 1);
    check("t1_vid_ack", vid_ack, 0);
    cpu_req = 1'b0;
    tick(2);

    // Tie from reset: CPU, VID, CPU, VID at 4-cycle spacing.
    do_reset();
    cpu_addr = 19'h00100; vid_addr = 19'h00200;
    cpu_req = 1'b1; vid_req = 1'b1;
    cpu_exp_q.push_back(8'hC1); vid_exp_q.push_back(8'hD2);
    cpu_exp_q.push_back(8'hC1); vid_exp_q.push_back(8'hD2);
    for (int k = 0; k < 4; k++) begin
      wait_any_ack("t2", cyc);
      check($sformatf("t2_cpu_turn%0d", k), cpu_ack, (k % 2) == 0);
      check($sformatf("t2_spacing%0d", k), cyc, (k == 0) ? 3 : 4);
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    tick(2);

    // Download session blocks reads; DONE pulses once after it ends.
    dn_active = 1'b1;
    cpu_addr = 19'h00123; cpu_req = 1'b1;
    cpu_exp_q.push_back(8'h5A);
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      dn_wr = 1'b1; dn_addr = 19'(i); dn_data = 8'(8'hA0 + i);
      tick(1);
      if (cpu_ack) acks++;
      dn_wr = 1'b0;
      tick(1);
      if (cpu_ack) acks++;
    end
    tick(2);
    if (cpu_ack) acks++;
    check("t3_no_ack_in_session", acks, 0);
    dn_active = 1'b0;
    dones = 0; acks = 0;
    repeat (15) begin
      tick(1);
      if (dn_done) dones++;
      if (cpu_ack) begin acks++; cpu_req = 1'b0; end
    end
    check("t3_done_pulses", dones, 1);
    check("t3_ack_after_session", acks, 1);
    check("t3_ovf", dn_ovf, 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_ram%0d", i), ram[i], 8'hA0 + i);
      $display("download byte addr=0x%02h ram=0x%02h", i, ram[i]);
    end

    // Overflow: two back-to-back download strobes while a read is active.
    cpu_addr = 19'h00123; cpu_req = 1'b1;
    cpu_exp_q.push_back(8'h5A);
    tick(1);
    dn_wr = 1'b1; dn_addr = 19'h00030; dn_data = 8'h77;
    tick(1);
    dn_addr = 19'h00031; dn_data = 8'h88;
    tick(1);
    dn_wr = 1'b0; cpu_req = 1'b0;
    check("t4_ack", cpu_ack, 1);
    check("t4_ovf_set", dn_ovf, 1);
    tick(6);
    check("t4_ovf_sticky", dn_ovf, 1);
    check("t4_ram_kept", ram[12'h030], 8'h77);
    check("t4_ram_dropped", ram[12'h031], 8'h00);
    dn_active = 1'b1;
    tick(1);
    check("t4_ovf_cleared", dn_ovf, 0);
    dn_active = 1'b0;
    tick(3);

    // Collision: download byte arrives on the IDLE->RD grant edge.
    cpu_addr = 19'h00123; cpu_req = 1'b1;
    cpu_exp_q.push_back(8'h5A);
    dn_wr = 1'b1; dn_addr = 19'h00040; dn_data = 8'h99;
    tick(1);
    dn_wr = 1'b0;
    cyc = 1;
    while (!cpu_ack && cyc < 20) begin tick(1); cyc++; end
    check("t5_latency", cyc, 3);
    cpu_req = 1'b0;
    tick(4);
    check("t5_ram", ram[12'h040], 8'h99);
    check("t5_ovf", dn_ovf, 0);

    // Asynchronous reset while the read is in RDW.
    cpu_addr = 19'h00123; cpu_req = 1'b1;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_cpu_ack", cpu_ack, 0);
    check("t6_cpu_data", cpu_data, 0);
    check("t6_mem_addr", mem_addr, 0);
    check("t6_mem_ce", mem_ce, 0);
    cpu_req = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("t6_no_ack", cpu_ack | vid_ack, 0);
    cpu_addr = 19'h00100; vid_addr = 19'h00200;
    cpu_req = 1'b1; vid_req = 1'b1;
    cpu_exp_q.push_back(8'hC1); vid_exp_q.push_back(8'hD2);
    wait_any_ack("t6a", cyc);
    check("t6_cpu_first", cpu_ack, 1);
    wait_any_ack("t6b", cyc);
    check("t6_vid_second", vid_ack, 1);
    cpu_req = 1'b0; vid_req = 1'b0;
    tick(4);
    check("sb_empty", cpu_exp_q.size() + vid_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dkong_rom_arbiter.md
Name: dkong_rom_arbiter

Overview:
- Shares one single-port program/graphics ROM block RAM among three requesters: the HPS download writer (ioctl byte stream), the CPU fetch path, and the video tile/sprite fetch path.
- Download writes have absolute priority and are buffered one deep. Reads are granted round-robin when no download traffic is pending.
- Sits inside dkong_top, between the dn_* download inputs, the CPU/video ROM read ports, and the ROM RAM instance.

Parameters:
- AW, 19, address width of download, read and memory ports.
- DW, 8, data width.

Ports:
- I_CLK_24576M  in  1  system clock.
- I_RESETn  in  1  asynchronous active-low reset.
- I_DN_ACTIVE  in  1  download session in progress (ioctl_download).
- I_DN_WR  in  1  one-cycle download byte strobe.
- I_DN_ADDR  in  AW  download byte address.
- I_DN_DATA  in  DW  download byte.
- I_CPU_REQ  in  1  CPU read request, level.
- I_CPU_ADDR  in  AW  CPU read address.
- O_CPU_DATA  out  DW  CPU read data.
- O_CPU_ACK  out  1  CPU read complete, one-cycle pulse.
- I_VID_REQ  in  1  video read request, level.
- I_VID_ADDR  in  AW  video read address.
- O_VID_DATA  out  DW  video read data.
- O_VID_ACK  out  1  video read complete, one-cycle pulse.
- O_MEM_ADDR  out  AW  RAM address.
- O_MEM_D  out  DW  RAM write data.
- O_MEM_WE  out  1  RAM write enable.
- O_MEM_CE  out  1  RAM enable.
- I_MEM_Q  in  DW  RAM read data, valid one cycle after the CE cycle.
- O_DN_OVF  out  1  sticky overflow: a download byte was lost.
- O_DN_DONE  out  1  one-cycle pulse when the download has fully drained.

Behaviour:
- Reset: async. All outputs 0, FSM in IDLE, buffer empty, last_grant=VID (so the CPU wins the first tie).
- Download buffer:
  - On I_DN_WR, latch addr/data and set buf_full. Capture happens in any FSM state.
  - I_DN_WR while buf_full and buffer not draining this cycle: byte dropped, O_DN_OVF<=1.
  - Drain (IDLE->WR) in the same cycle as a new I_DN_WR: new byte accepted, no overflow.
  - O_DN_OVF clears only on reset or on a rising edge of I_DN_ACTIVE.
- FSM states: IDLE, WR, RD, RDW, ACK. All memory outputs and acks are registered.
- IDLE:
  - If buf_full: go to WR.
  - Else if I_DN_ACTIVE=1: stay in IDLE; reads are blocked for the whole session.
  - Else if a read request exists: go to RD and record the grant.
  - When both CPU and VID request, grant the requester that is not last_grant. Update last_grant on each grant.
- WR: O_MEM_CE=1, O_MEM_WE=1, O_MEM_ADDR/O_MEM_D come from the buffer, for exactly one cycle. buf_full clears. Next state IDLE.
- RD: O_MEM_CE=1, WE=0, O_MEM_ADDR = granted requester's address. Next state RDW.
- RDW: capture I_MEM_Q into the granted requester's O_*_DATA. Next state ACK.
- ACK: granted O_*_ACK=1 for this one cycle. Requests are not sampled in ACK. Next state IDLE.
- Read latency: request first sampled in IDLE at edge N -> ack high in cycle N+3. Back-to-back read throughput is one read per 4 cycles.
- Requester rules:
  - Hold REQ and ADDR stable until ACK.
  - May deassert REQ at the edge ending ACK.
  - A request dropped before grant is simply not served.
- O_*_DATA holds its last value between reads.
- A download byte arriving during RD/RDW/ACK waits in the buffer. It is written within 4 cycles of arrival, after the current read finishes (ACK -> IDLE -> WR).
- O_DN_DONE: one-cycle pulse on the first cycle where I_DN_ACTIVE=0, buf_full=0 and state != WR, following a falling edge of I_DN_ACTIVE.
- Reset mid-read: no ack is issued; the buffered byte is lost.
- Address and data are passed through without arithmetic; there is no wrap-around handling.

Decomposition:
- Package dkong_arb_pkg:
  - state enum {IDLE, WR, RD, RDW, ACK}.
  - grant enum {G_CPU, G_VID}.
  - localparams READ_LAT=3, ACC_CYCLES=4.
- Sub-module dkong_rr_pick: 2-way round-robin chooser. Inputs are req[1:0] and last; output is the grant. Combinational, kept separate for unit test.

Test Plan:
- Reset then single read: I_CPU_REQ=1, addr=0x00123, RAM holds 0x5A -> O_CPU_ACK high exactly 3 cycles after the first IDLE sample, O_CPU_DATA=0x5A, O_VID_ACK stays 0.
- Tie: CPU and VID requesting continuously from reset -> grants alternate CPU, VID, CPU, VID; each ack spaced 4 cycles apart.
- Download stream: I_DN_ACTIVE=1, I_DN_WR every 2 cycles, 16 bytes to 0x00000-0x0000F -> RAM contents match, O_DN_OVF=0. A CPU request held throughout gets no ack until after the falling edge of I_DN_ACTIVE; O_DN_DONE pulses once.
- Overflow: I_DN_WR on two consecutive cycles while the FSM is in RD -> the second byte is dropped, O_DN_OVF=1 and remains 1. A new I_DN_ACTIVE rising edge clears it.
- Collision: I_DN_WR arrives in the same cycle as an IDLE->RD grant -> the read completes (ack at +3), then WR occurs; the written byte is verified in RAM.
- Async reset asserted during RDW -> all outputs 0 immediately, no ack pulse. After release, the CPU is granted first on a tie.
